// File: rtl/tx_resp_buffer_pkg.sv
// Shared definitions for the TX response buffer slice.
//   WIDTH          : byte width carried to the UART
//   WIDTH_OUT_ALU  : width of an ALU result word (two bytes)
//   tx_state_t     : transmit FSM state encoding (also exported for debug)
package tx_resp_buffer_pkg;

  localparam int WIDTH         = 8;
  localparam int WIDTH_OUT_ALU = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/tx_resp_buffer_byte_fifo.sv
// byte_fifo: byte FIFO with two write ports and one read port.
//   clk, reset_n       : clock, asynchronous active-low reset (pointers/count only)
//   wr0_en, wr0_data   : first byte of a push, written at the write pointer
//   wr1_en, wr1_data   : second byte of a push, written one slot after wr0;
//                        only meaningful together with wr0_en
//   rd_en              : pop the head byte (ignored when empty)
//   rd_data            : current head byte (combinational)
//   count              : bytes stored, registered
//   full               : registered, set when fewer than 2 slots are free
module byte_fifo
  import tx_resp_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr0_en,
  input  logic [WIDTH-1:0]           wr0_data,
  input  logic                       wr1_en,
  input  logic [WIDTH-1:0]           wr1_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_ok;
  logic [CW-1:0]    count_next;

  assign rd_ok      = rd_en && (count != '0);
  assign count_next = count + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_ok);
  assign rd_data    = mem[rd_ptr];

  // Storage carries no reset; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr_ptr] <= wr0_data;
    if (wr1_en) mem[wr_ptr + AW'(1)] <= wr1_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr0_en) + AW'(wr1_en);
      rd_ptr <= rd_ptr + AW'(rd_ok);
      count  <= count_next;
      full   <= (count_next > CW'(DEPTH - 2));
    end
  end

endmodule

// File: rtl/tx_resp_buffer.sv
// tx_resp_buffer: queues register-file bytes and ALU words and feeds them one
// byte at a time to a UART transmitter.
//   clk, reset_n                         : clock, asynchronous active-low reset
//   rf_rd_data_in / rf_rd_data_valid_in  : one-byte response push
//   alu_data_in / alu_data_valid_in      : two-byte push, low byte first
//   uart_tx_busy_in                      : UART busy (synchronous to clk)
//   clr_ovf_in                           : clears overflow_out
//   uart_tx_data_out / _valid_out        : byte and one-cycle send strobe
//   full_out, count_out                  : registered FIFO status
//   overflow_out                         : sticky dropped-push flag
//   state_out                            : transmit FSM state (debug)
//
// Strobe semantics: a *_valid_in high for one cycle offers its data in that
// cycle only; there is no ready. A push that cannot be taken whole is dropped
// and recorded in overflow_out. uart_tx_data_valid_out is likewise a one-cycle
// offer; acceptance is inferred from uart_tx_busy_in rising afterwards.
module tx_resp_buffer
  import tx_resp_buffer_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         rf_rd_data_in,
  input  logic                     rf_rd_data_valid_in,
  input  logic [WIDTH_OUT_ALU-1:0] alu_data_in,
  input  logic                     alu_data_valid_in,
  input  logic                     uart_tx_busy_in,
  input  logic                     clr_ovf_in,
  output logic [WIDTH-1:0]         uart_tx_data_out,
  output logic                     uart_tx_data_valid_out,
  output logic                     full_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     overflow_out,
  output tx_state_t                state_out
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  tx_state_t        state;
  logic [TW-1:0]    busy_timer;
  logic [CW-1:0]    free_cnt;
  logic             alu_fit;
  logic             rf_fit;
  logic             alu_push;
  logic             rf_push;
  logic             ovf_event;
  logic             wr0_en;
  logic [WIDTH-1:0] wr0_data;
  logic [WIDTH-1:0] head;

  // Room is judged on the pre-pop count so a pop in the same cycle never
  // makes space for a push.
  assign free_cnt = CW'(DEPTH) - count_out;
  assign alu_fit  = (free_cnt >= CW'(2));
  assign rf_fit   = (free_cnt != '0);

  // ALU has priority; an RF byte arriving alongside it is always lost.
  assign alu_push  = alu_data_valid_in && alu_fit;
  assign rf_push   = rf_rd_data_valid_in && !alu_data_valid_in && rf_fit;
  assign ovf_event = (alu_data_valid_in && rf_rd_data_valid_in)
                   || (alu_data_valid_in && !alu_fit)
                   || (rf_rd_data_valid_in && !alu_data_valid_in && !rf_fit);

  assign wr0_en   = alu_push || rf_push;
  assign wr0_data = alu_push ? alu_data_in[WIDTH-1:0] : rf_rd_data_in;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr0_en   (wr0_en),
    .wr0_data (wr0_data),
    .wr1_en   (alu_push),
    .wr1_data (alu_data_in[WIDTH_OUT_ALU-1:WIDTH]),
    .rd_en    (state == SEND),
    .rd_data  (head),
    .count    (count_out),
    .full     (full_out)
  );

  // Data and strobe are registered on the IDLE->SEND transition so they are
  // presented during the SEND cycle; the head cannot move before that pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      busy_timer             <= '0;
      uart_tx_data_out       <= '0;
      uart_tx_data_valid_out <= 1'b0;
    end else begin
      uart_tx_data_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if ((count_out != '0) && !uart_tx_busy_in) begin
            state                  <= SEND;
            uart_tx_data_out       <= head;
            uart_tx_data_valid_out <= 1'b1;
          end
        end
        SEND: begin
          state      <= WAIT_BUSY;
          busy_timer <= '0;
        end
        WAIT_BUSY: begin
          // No busy within BUSY_TIMEOUT cycles: treat the byte as lost.
          if (uart_tx_busy_in) begin
            state <= WAIT_DONE;
          end else if (busy_timer == TW'(BUSY_TIMEOUT - 1)) begin
            state <= IDLE;
          end else begin
            busy_timer <= busy_timer + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!uart_tx_busy_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_out <= 1'b0;
    end else if (ovf_event) begin
      overflow_out <= 1'b1;
    end else if (clr_ovf_in) begin
      overflow_out <= 1'b0;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_tx_resp_buffer.sv
// Self-checking bench for tx_resp_buffer (DEPTH=8, BUSY_TIMEOUT=4).
module tb_tx_resp_buffer;
  import tx_resp_buffer_pkg::*;

  localparam int DEPTH        = 8;
  localparam int BUSY_TIMEOUT = 4;
  localparam int CW           = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [7:0]    rf_rd_data_in;
  logic          rf_rd_data_valid_in;
  logic [15:0]   alu_data_in;
  logic          alu_data_valid_in;
  logic          uart_tx_busy_in;
  logic          clr_ovf_in;
  logic [7:0]    uart_tx_data_out;
  logic          uart_tx_data_valid_out;
  logic          full_out;
  logic [CW-1:0] count_out;
  logic          overflow_out;
  tx_state_t     state_out;

  tx_resp_buffer #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .rf_rd_data_in          (rf_rd_data_in),
    .rf_rd_data_valid_in    (rf_rd_data_valid_in),
    .alu_data_in            (alu_data_in),
    .alu_data_valid_in      (alu_data_valid_in),
    .uart_tx_busy_in        (uart_tx_busy_in),
    .clr_ovf_in             (clr_ovf_in),
    .uart_tx_data_out       (uart_tx_data_out),
    .uart_tx_data_valid_out (uart_tx_data_valid_out),
    .full_out               (full_out),
    .count_out              (count_out),
    .overflow_out           (overflow_out),
    .state_out              (state_out)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  int cyc = 0;
  int last_strobe_cyc = 0;
  int prev_strobe_cyc = 0;
  bit busy_mode = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Output monitor: every strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && uart_tx_data_valid_out === 1'b1) begin
      strobe_cnt++;
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
      check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("strobe_data", uart_tx_data_out, exp_q.pop_front());
    end
  end

  // UART model: raises busy 3 cycles after each strobe, holds it 3 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (busy_mode && uart_tx_data_valid_out === 1'b1) begin
        repeat (3) @(posedge clk);
        #1 uart_tx_busy_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 uart_tx_busy_in = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [15:0] v, input bit accept);
    if (accept) begin
      exp_q.push_back(v[7:0]);
      exp_q.push_back(v[15:8]);
    end
    alu_data_in       = v;
    alu_data_valid_in = 1'b1;
    tick();
    alu_data_valid_in = 1'b0;
  endtask

  task automatic drive_rf(input logic [7:0] v, input bit accept);
    if (accept) exp_q.push_back(v);
    rf_rd_data_in       = v;
    rf_rd_data_valid_in = 1'b1;
    tick();
    rf_rd_data_valid_in = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_ovf_in = 1'b1;
    tick();
    clr_ovf_in = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && !(state_out == IDLE && !uart_tx_busy_in); i++) tick();
    check(tag, 32'(state_out == IDLE && !uart_tx_busy_in), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    reset_n             = 1'b0;
    rf_rd_data_in       = '0;
    rf_rd_data_valid_in = 1'b0;
    alu_data_in         = '0;
    alu_data_valid_in   = 1'b0;
    uart_tx_busy_in     = 1'b0;
    clr_ovf_in          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", count_out, 0);
    check("rst_full", full_out, 0);
    check("rst_ovf", overflow_out, 0);
    check("rst_valid", uart_tx_data_valid_out, 0);
    check("rst_data", uart_tx_data_out, 0);
    check("rst_state", state_out, IDLE);
    reset_n = 1'b1;
    tick();

    // ALU word, busy handshake, 2-cycle latency
    busy_mode = 1'b1;
    drive_alu(16'hBEEF, 1'b1);
    check("t1_count2", count_out, 2);
    tick();
    check("t1_latency", uart_tx_data_valid_out, 1);
    wait_drain(60, "t1_drain");
    check("t1_count0", count_out, 0);
    check("t1_ovf", overflow_out, 0);
    wait_idle(40, "t1_idle");

    // simultaneous RF and ALU: RF byte lost
    s0 = strobe_cnt;
    rf_rd_data_in = 8'h11;
    rf_rd_data_valid_in = 1'b1;
    drive_alu(16'h2233, 1'b1);
    rf_rd_data_valid_in = 1'b0;
    check("t2_ovf", overflow_out, 1);
    wait_drain(60, "t2_drain");
    wait_idle(40, "t2_idle");
    check("t2_strobes", strobe_cnt - s0, 2);
    pulse_clr();
    check("t2_clr", overflow_out, 0);

    // fill to 7, drops, clear priority, fill to 8
    busy_mode = 1'b0;
    uart_tx_busy_in = 1'b1;
    drive_alu(16'h0201, 1'b1);
    drive_alu(16'h0403, 1'b1);
    drive_alu(16'h0605, 1'b1);
    drive_rf(8'h07, 1'b1);
    check("t3_count7", count_out, 7);
    check("t3_full7", full_out, 1);
    drive_alu(16'hCAFE, 1'b0);
    check("t3_drop_count", count_out, 7);
    check("t3_drop_ovf", overflow_out, 1);
    pulse_clr();
    check("t3_clr", overflow_out, 0);
    clr_ovf_in = 1'b1;
    drive_alu(16'hCAFE, 1'b0);
    clr_ovf_in = 1'b0;
    check("t3_ovf_wins", overflow_out, 1);
    check("t3_count_still7", count_out, 7);
    pulse_clr();
    drive_rf(8'h08, 1'b1);
    check("t3_count8", count_out, 8);
    check("t3_ovf_rf_fit", overflow_out, 0);
    drive_rf(8'h09, 1'b0);
    check("t3_rf_drop_ovf", overflow_out, 1);
    check("t3_rf_drop_count", count_out, 8);
    pulse_clr();
    busy_mode = 1'b1;
    uart_tx_busy_in = 1'b0;
    wait_drain(200, "t3_drain");
    check("t3_count0", count_out, 0);
    wait_idle(40, "t3_idle");

    // push at 6 with a simultaneous pop
    busy_mode = 1'b0;
    uart_tx_busy_in = 1'b1;
    drive_alu(16'h1112, 1'b1);
    drive_alu(16'h1314, 1'b1);
    drive_alu(16'h1516, 1'b1);
    check("t4_count6", count_out, 6);
    check("t4_full6", full_out, 0);
    busy_mode = 1'b1;
    uart_tx_busy_in = 1'b0;
    tick();
    check("t4_send", state_out, SEND);
    drive_alu(16'h1718, 1'b1);
    check("t4_count7", count_out, 7);
    check("t4_no_ovf", overflow_out, 0);
    check("t4_full7", full_out, 1);
    wait_drain(200, "t4_drain");
    wait_idle(40, "t4_idle");

    // WAIT_BUSY timeout
    busy_mode = 1'b0;
    drive_alu(16'h6655, 1'b1);
    wait_drain(60, "t5_drain");
    check("t5_gap", last_strobe_cyc - prev_strobe_cyc, BUSY_TIMEOUT + 2);
    wait_idle(40, "t5_idle");
    check("t5_count0", count_out, 0);

    // reset during WAIT_DONE with 3 bytes queued
    busy_mode = 1'b1;
    drive_alu(16'hA2A1, 1'b1);
    drive_alu(16'hA4A3, 1'b1);
    for (int i = 0; i < 30 && state_out != WAIT_DONE; i++) tick();
    check("t6_wait_done", state_out, WAIT_DONE);
    check("t6_count3", count_out, 3);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_count", count_out, 0);
    check("t6_rst_state", state_out, IDLE);
    check("t6_rst_valid", uart_tx_data_valid_out, 0);
    check("t6_rst_data", uart_tx_data_out, 0);
    exp_q.delete();
    s0 = strobe_cnt;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (30) tick();
    check("t6_no_strobe", strobe_cnt - s0, 0);
    check("t6_count0", count_out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
